// File: rtl/irq_controller.sv
// irq_controller: latches peripheral IRQ pulses into flags, gates them by
// enable and per-pair priority, and presents one request to the CPU using a
// req/ack handshake. Flags are bus-readable and cleared by writing 1s.
//
// state | meaning
// IDLE  | no request presented; waiting for an eligible flag
// REQ   | irq_req=1; vector/level track the current winner until ack
// ACKD  | request accepted; one ce cycle of irq_req=0 before the next one
module irq_controller #(
    parameter logic [23:0] IRQ_PRI  = 24'h2020,
    parameter logic [23:0] IRQ_ENA  = 24'h2023,
    parameter logic [23:0] IRQ_ACT  = 24'h2027,
    parameter logic [7:0]  VEC_BASE = 8'h03
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_ce,
    input  logic        bus_write,
    input  logic        bus_read,
    input  logic [23:0] bus_address_in,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    input  logic [7:0]  irq_in,
    input  logic [1:0]  cpu_ilevel,
    input  logic        irq_ack,
    output logic        irq_req,
    output logic [7:0]  irq_vector,
    output logic [1:0]  irq_level
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACKD = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_pri;
    logic [7:0] r_ena;
    logic [7:0] r_act;
    logic       r_req;
    logic [7:0] r_vector;
    logic [1:0] r_level;

    logic       w_wr_pri;
    logic       w_wr_ena;
    logic       w_wr_act;
    logic       w_any;
    logic [2:0] w_win_idx;
    logic [1:0] w_win_pri;
    logic [7:0] w_win_vec;
    logic       w_unused;

    // bus_read has no side effects; reads are decoded from the address alone
    assign w_unused = bus_read;

    assign w_wr_pri = clk_ce & bus_write & (bus_address_in == IRQ_PRI);
    assign w_wr_ena = clk_ce & bus_write & (bus_address_in == IRQ_ENA);
    assign w_wr_act = clk_ce & bus_write & (bus_address_in == IRQ_ACT);

    function automatic logic [1:0] prio_of(input logic [7:0] pri, input int idx);
        return pri[(idx / 2) * 2 +: 2];
    endfunction

    // Winner: highest priority among eligible flags; strict compare keeps the lowest index on ties
    always_comb begin
        w_any     = 1'b0;
        w_win_idx = 3'd0;
        w_win_pri = 2'd0;
        for (int i = 0; i < 8; i++) begin
            if (r_act[i] && r_ena[i] && (prio_of(r_pri, i) != 2'd0) &&
                (prio_of(r_pri, i) > cpu_ilevel) &&
                (!w_any || (prio_of(r_pri, i) > w_win_pri))) begin
                w_any     = 1'b1;
                w_win_idx = 3'(i);
                w_win_pri = prio_of(r_pri, i);
            end
        end
    end

    assign w_win_vec = VEC_BASE + {5'd0, w_win_idx};

    // Read mux, combinational from the address
    always_comb begin
        bus_data_out = 8'h00;
        if (bus_address_in == IRQ_PRI)      bus_data_out = r_pri;
        else if (bus_address_in == IRQ_ENA) bus_data_out = r_ena;
        else if (bus_address_in == IRQ_ACT) bus_data_out = r_act;
    end

    // Config registers and flags; a new pulse overrides a same-cycle write-1-clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pri <= 8'h00;
            r_ena <= 8'h00;
            r_act <= 8'h00;
        end else if (clk_ce) begin
            if (w_wr_pri) r_pri <= bus_data_in;
            if (w_wr_ena) r_ena <= bus_data_in;
            r_act <= (r_act & ~(w_wr_act ? bus_data_in : 8'h00)) | irq_in;
        end
    end

    // Request handshake FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_req    <= 1'b0;
            r_vector <= 8'h00;
            r_level  <= 2'd0;
        end else if (clk_ce) begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state  <= REQ;
                        r_req    <= 1'b1;
                        r_vector <= w_win_vec;
                        r_level  <= w_win_pri;
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        r_state <= ACKD;
                        r_req   <= 1'b0;
                    end else if (!w_any) begin
                        r_state <= IDLE;
                        r_req   <= 1'b0;
                    end else begin
                        r_vector <= w_win_vec;
                        r_level  <= w_win_pri;
                    end
                end
                ACKD: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign irq_req    = r_req;
    assign irq_vector = r_vector;
    assign irq_level  = r_level;

endmodule
